// File: rtl/pkt_proc_pkg.sv
// Shared types and constants for the packet dequeue controller.
package pkt_proc_pkg;

    localparam int DEQ_FIFO_DEPTH = 4;
    localparam int DEQ_DATA_WIDTH = 32;
    localparam int DEQ_CNT_WIDTH  = $clog2(DEQ_FIFO_DEPTH + 1);

    typedef enum logic {
        DEQ_IDLE,
        DEQ_READ
    } deq_state_e;

    typedef struct packed {
        logic                      sop;
        logic                      eop;
        logic [DEQ_DATA_WIDTH-1:0] data;
    } deq_entry_t;

endpackage

// File: rtl/pkt_deq_fifo.sv
// Small skid FIFO holding framed read-return words until downstream accepts them.
module pkt_deq_fifo
    import pkt_proc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  deq_entry_t               push_entry,
    input  logic                     pop,
    output deq_entry_t               head,
    output logic [DEQ_CNT_WIDTH-1:0] count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEQ_FIFO_DEPTH);

    deq_entry_t       storage [DEQ_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + DEQ_CNT_WIDTH'(push) - DEQ_CNT_WIDTH'(pop);
        end
    end

    // NOTE: storage has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= push_entry;
    end

    assign head  = storage[rd_ptr];
    assign empty = (count == '0);

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == DEQ_CNT_WIDTH'(DEQ_FIFO_DEPTH)));

endmodule

// File: rtl/pkt_deq_ctrl.sv
// Egress reader: walks one descriptor's words out of the buffer RAM and re-frames
// them into a backpressured sop/eop stream through a credit-limited skid FIFO.
module pkt_deq_ctrl
    import pkt_proc_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = DEQ_DATA_WIDTH,
    parameter int PCK_LEN    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [PCK_LEN-1:0]    desc_len,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_rd,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  pkt_done,
    output logic                  desc_err,
    output logic                  busy
);

    deq_state_e               state, state_nxt;
    logic [ADDR_WIDTH-1:0]    base_addr;
    logic [PCK_LEN-1:0]       pkt_len;
    logic [PCK_LEN-1:0]       rd_cnt;
    logic                     inflight, inflight_sop, inflight_eop;
    logic                     desc_err_q;

    deq_entry_t               push_entry, fifo_head;
    logic [DEQ_CNT_WIDTH-1:0] fifo_count;
    logic                     fifo_empty, pop;
    logic                     credit_ok, last_rd, desc_take;

    // Credit ignores same-cycle pops so a read never depends on out_ready combinationally.
    assign credit_ok = (fifo_count + DEQ_CNT_WIDTH'(inflight)) < DEQ_CNT_WIDTH'(DEQ_FIFO_DEPTH);
    assign last_rd   = (rd_cnt == pkt_len - PCK_LEN'(1));
    assign desc_take = desc_valid && desc_ready;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        desc_ready  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr_rd = '0;
        case (state)
            DEQ_IDLE: begin
                desc_ready = !rst;
                if (desc_valid && !rst && desc_len != '0) state_nxt = DEQ_READ;
            end
            DEQ_READ: begin
                if (credit_ok && !rst) begin
                    mem_rd_en   = 1'b1;
                    mem_addr_rd = base_addr + ADDR_WIDTH'(rd_cnt);
                    if (last_rd) state_nxt = DEQ_IDLE;
                end
            end
            default: state_nxt = DEQ_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DEQ_IDLE;
            base_addr    <= '0;
            pkt_len      <= '0;
            rd_cnt       <= '0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
            desc_err_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            inflight   <= mem_rd_en;
            desc_err_q <= desc_take && (desc_len == '0);
            if (desc_take && desc_len != '0) begin
                base_addr <= desc_addr;
                pkt_len   <= desc_len;
                rd_cnt    <= '0;
            end
            if (mem_rd_en) begin
                rd_cnt       <= rd_cnt + PCK_LEN'(1);
                inflight_sop <= (rd_cnt == '0);
                inflight_eop <= last_rd;
            end
        end
    end

    assign push_entry = '{sop: inflight_sop, eop: inflight_eop, data: mem_data_in};

    pkt_deq_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    // Head fields are masked while empty or in reset so idle outputs read as zero.
    assign out_valid = !fifo_empty && !rst;
    assign out_data  = out_valid ? fifo_head.data : '0;
    assign out_sop   = out_valid && fifo_head.sop;
    assign out_eop   = out_valid && fifo_head.eop;
    assign pop       = out_valid && out_ready;
    assign pkt_done  = pop && fifo_head.eop;
    assign desc_err  = desc_err_q && !rst;
    assign busy      = !rst && ((state != DEQ_IDLE) || inflight || !fifo_empty);

endmodule

// File: tb/tb_pkt_deq_ctrl.sv
// Self-checking bench for pkt_deq_ctrl: RAM model, word-level scoreboard and directed/random scenarios.
module tb_pkt_deq_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          desc_valid, desc_ready;
    logic [AW-1:0] desc_addr;
    logic [LW-1:0] desc_len;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr_rd;
    logic [DW-1:0] mem_data_in;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop, out_eop, pkt_done, desc_err, busy;

    pkt_deq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PCK_LEN(LW)) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len),
        .mem_rd_en(mem_rd_en), .mem_addr_rd(mem_addr_rd), .mem_data_in(mem_data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop),
        .pkt_done(pkt_done), .desc_err(desc_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000 + DW'(a);
    endfunction

    // Buffer RAM: one-cycle read latency, junk when not read.
    always @(posedge clk) mem_data_in <= mem_rd_en ? mem_word(mem_addr_rd) : DW'($urandom());

    // out_ready driver: 0 = always ready, 1 = random 50%, 2 = held low.
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Reference model: every accepted descriptor expands into its expected words and read addresses.
    typedef struct {
        bit            sop;
        bit            eop;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] rd_log[$];
    int  outstanding = 0;
    int  n_sop = 0, n_eop = 0, n_done = 0, n_err = 0, n_pops = 0;
    bit  err_pending = 0;
    bit  prev_stall = 0;
    logic [DW+1:0] prev_head;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs",
                  {desc_ready, mem_rd_en, out_valid, out_sop, out_eop, pkt_done, desc_err, busy, mem_addr_rd, out_data},
                  64'd0);
            exp_q.delete();
            addr_q.delete();
            outstanding = 0;
            err_pending = 0;
            prev_stall  = 0;
        end else begin
            check("busy", busy, exp_q.size() != 0);
            check("desc_err", desc_err, err_pending);
            if (desc_err) n_err++;
            err_pending = desc_valid && desc_ready && (desc_len == '0);
            if (desc_valid && desc_ready && desc_len != '0) begin
                for (int i = 0; i < int'(desc_len); i++) begin
                    logic [AW-1:0] a;
                    a = desc_addr + AW'(i);
                    addr_q.push_back(a);
                    exp_q.push_back('{sop: (i == 0), eop: (i == int'(desc_len) - 1), data: mem_word(a)});
                end
            end
            if (mem_rd_en) begin
                check("read_credit", outstanding < 4, 1'b1);
                rd_log.push_back(mem_addr_rd);
                if (addr_q.size() == 0) check("read_unexpected", 1'b1, 1'b0);
                else check("read_addr", mem_addr_rd, addr_q.pop_front());
                outstanding++;
            end
            if (prev_stall)
                check("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, prev_head});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1'b1, 1'b0);
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_sop", out_sop, exp_q[0].sop);
                    check("out_eop", out_eop, exp_q[0].eop);
                    if (out_ready) begin
                        check("pkt_done", pkt_done, exp_q[0].eop);
                        if (out_sop)  n_sop++;
                        if (out_eop)  n_eop++;
                        if (pkt_done) n_done++;
                        void'(exp_q.pop_front());
                        outstanding--;
                        n_pops++;
                    end
                end
            end
            if (!(out_valid && out_ready)) check("pkt_done_idle", pkt_done, 1'b0);
            prev_stall = out_valid && !out_ready;
            prev_head  = {out_sop, out_eop, out_data};
        end
    end

    task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit ok = 0;
        @(posedge clk); #1;
        desc_valid = 1'b1; desc_addr = a; desc_len = l;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (desc_ready) begin ok = 1; break; end
        end
        if (!ok) check("desc_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        desc_valid = 1'b0; desc_len = '0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check("drain_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s_sop, s_eop, s_done, s_err;
        logic [DW-1:0] beats[4];
        bit done4[4];

        rst = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: basic packet, latency and literal data
        rd_log.delete();
        send_desc(14'h0010, 12'd4);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("t1_first_valid_latency", k, 3);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            beats[b] = out_data;
            done4[b] = pkt_done;
        end
        check("t1_beat0", beats[0], 32'hA010);
        check("t1_beat3", beats[3], 32'hA013);
        check("t1_done_pattern", {done4[0], done4[1], done4[2], done4[3]}, 4'b0001);
        wait_drain();
        check("t1_nreads", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            check("t1_rd0", rd_log[0], 14'h0010);
            check("t1_rd3", rd_log[3], 14'h0013);
        end

        // 2: address wrap
        rd_log.delete();
        send_desc(14'h3FFE, 12'd4);
        wait_drain();
        check("t2_nreads", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            check("t2_rd0", rd_log[0], 14'h3FFE);
            check("t2_rd1", rd_log[1], 14'h3FFF);
            check("t2_rd2", rd_log[2], 14'h0000);
            check("t2_rd3", rd_log[3], 14'h0001);
        end

        // 3: len 1, illegal len 0, len 2
        s_sop = n_sop; s_eop = n_eop; s_err = n_err;
        send_desc(14'h0040, 12'd1);
        send_desc(14'h0100, 12'd0);
        send_desc(14'h0200, 12'd2);
        wait_drain();
        check("t3_err_count", n_err - s_err, 1);
        check("t3_sop_count", n_sop - s_sop, 2);
        check("t3_eop_count", n_eop - s_eop, 2);

        // 4: backpressure stall
        ready_mode = 2;
        repeat (2) @(posedge clk);
        rd_log.delete();
        send_desc(14'h0500, 12'd10);
        repeat (8) @(negedge clk);
        check("t4_reads_in_stall", rd_log.size(), 4);
        check("t4_rd_en_low", mem_rd_en, 1'b0);
        check("t4_head_word", {out_valid, out_sop, out_data}, {2'b11, 32'hA500});
        ready_mode = 0;
        wait_drain();
        check("t4_total_reads", rd_log.size(), 10);

        // 5: random traffic under random backpressure
        ready_mode = 1;
        s_sop = n_sop; s_eop = n_eop; s_done = n_done;
        for (int p = 0; p < 20; p++) begin
            send_desc(AW'($urandom()), LW'($urandom_range(1, 64)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_drain();
        check("t5_sop_count", n_sop - s_sop, 20);
        check("t5_eop_count", n_eop - s_eop, 20);
        check("t5_done_count", n_done - s_done, 20);

        // 6: reset mid-packet, then a clean packet
        ready_mode = 0;
        repeat (2) @(posedge clk);
        s_done = n_done;
        k = n_pops;
        send_desc(14'h0800, 12'd8);
        for (int c = 0; c < 50 && n_pops < k + 3; c++) begin
            @(posedge clk); #1;
        end
        check("t6_three_words", n_pops - k, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_reset_idle",
              {mem_rd_en, out_valid, out_sop, out_eop, pkt_done, desc_err, busy}, 7'd0);
        check("t6_desc_ready", desc_ready, 1'b1);
        send_desc(14'h0900, 12'd5);
        wait_drain();
        check("t6_done_count", n_done - s_done, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_deq_ctrl.md
Name: pkt_deq_ctrl

Overview:
- Egress-side reader for the packet buffer RAM.
- Accepts one packet descriptor at a time (start address, word count) over a valid/ready handshake.
- Issues single-word reads to the buffer RAM, which has a fixed 1-cycle read latency.
- Re-frames the returned words into a backpressured output stream with sop/eop markers.
- An internal 4-entry skid FIFO absorbs read latency, so throughput is 1 word/cycle under continuous out_ready.

Parameters:
- ADDR_WIDTH, 14: buffer RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- PCK_LEN, 12: width of the descriptor length field (word count).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, synchronous and active-high.
- desc_valid, input, 1: descriptor offered.
- desc_ready, output, 1: descriptor accepted when desc_valid and desc_ready are both high.
- desc_addr, input, ADDR_WIDTH: first word address of the packet.
- desc_len, input, PCK_LEN: packet length in words; 0 is illegal.
- mem_rd_en, output, 1: buffer RAM read strobe.
- mem_addr_rd, output, ADDR_WIDTH: buffer RAM read address.
- mem_data_in, input, DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.
- out_valid, output, 1: output word valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_WIDTH: packet word.
- out_sop, output, 1: first word of packet.
- out_eop, output, 1: last word of packet.
- pkt_done, output, 1: 1-cycle pulse on the cycle the eop word handshakes.
- desc_err, output, 1: 1-cycle pulse when a desc_len==0 descriptor is consumed.
- busy, output, 1: high when the FSM is not IDLE, a read is in flight, or the FIFO is non-empty.

Behaviour:
- Reset (sync, rst=1 sampled at posedge):
  - FSM returns to IDLE; FIFO is flushed; in-flight flag cleared; word counter cleared.
  - All outputs are 0 during and after reset, including desc_ready (0 while rst=1).
  - Read data returning in the cycle after reset is discarded.
  - A mid-packet reset truncates the packet silently: no eop, no pkt_done.
- FSM states:
  - IDLE: desc_ready=1.
    - Handshake with desc_len!=0: latch addr/len, rd_cnt=0, go to READ.
    - Handshake with desc_len==0: pulse desc_err next cycle, stay in IDLE, no output.
  - READ: desc_ready=0. mem_rd_en=1 when credit is available.
    - Credit rule: fifo_count + inflight < 4. Pops in the same cycle are not counted (conservative).
    - On each read: mem_addr_rd = latched addr + rd_cnt, truncated to ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 to 0); rd_cnt increments.
    - When the read with rd_cnt == len-1 issues, return to IDLE the next cycle.
    - The next descriptor may be accepted while the previous packet is still draining from the FIFO; packets never interleave.
- mem_rd_en and mem_addr_rd are combinational from state, registers and FIFO count. mem_addr_rd is don't-care when mem_rd_en=0 and is driven 0.
- Data capture:
  - The inflight register is set on a read cycle.
  - On the next cycle, {sop=(rd index==0), eop=(rd index==len-1), mem_data_in} is pushed into the FIFO.
  - FIFO overflow is impossible by the credit rule; an assertion checks it.
- Output:
  - out_valid = FIFO non-empty; out_data/out_sop/out_eop come from the FIFO head.
  - Pop on out_valid && out_ready.
  - Output is held stable while out_valid && !out_ready.
- Latency: descriptor handshake at cycle T → mem_rd_en at T+1 → push at end of T+2 → out_valid with sop at T+3.
- Throughput: with out_ready held high, one word per cycle; next packet sop follows 2 cycles after the previous packet's last read issue, plus the pipeline.
- len==1: a single word carries sop=1 and eop=1.
- Backpressure: out_ready=0 stalls reads once fifo_count+inflight reaches 4; reads resume the cycle after a pop frees credit.
- pkt_done: asserted in the same cycle as the eop handshake, registered-free (combinational from pop && head eop).
- Maximum len is 2^PCK_LEN-1; rd_cnt is PCK_LEN bits wide and never wraps.

Decomposition:
- Package pkt_proc_pkg:
  - deq_state_e enum {DEQ_IDLE, DEQ_READ}.
  - Typedef deq_entry_t struct {sop, eop, data[DATA_WIDTH-1:0]}.
  - Constant DEQ_FIFO_DEPTH=4.
- Sub-module pkt_deq_fifo: 4-entry synchronous FIFO of deq_entry_t.
  - Same clk/rst.
  - Provides push, pop, head, count and empty.
  - Flushes on rst.

Test Plan:
- desc addr=0x0010 len=4, out_ready=1, mem returns addr+0xA000 → reads at 0x10..0x13; out_data 0xA010..0xA013; sop on the first word, eop on the fourth; first out_valid at T+3; pkt_done on the 4th beat.
- desc addr=0x3FFE len=4 → mem_addr_rd sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; data order preserved.
- len=1 then len=0 then len=2 back-to-back:
  - One beat with sop=eop=1.
  - desc_err pulses once with no output.
  - A 2-word packet follows with correct markers and no interleave.
- desc len=10 with out_ready=0 for 8 cycles:
  - Exactly 4 reads issue, then mem_rd_en stays low.
  - out_data is stable during the stall.
  - After release, all 10 words arrive in order with no loss or duplication.
- Random out_ready (50%) over 20 packets of random len 1..64 → scoreboard matches every word; sop/eop counts both equal 20; pkt_done count is 20.
- rst=1 asserted mid-packet (after word 3 of 8) → next cycle all outputs 0 and busy=0; a new descriptor after reset produces a clean packet with no stale words.
